wb_select_buffer: RTL
=====================

# wb_select_buffer

Parametrised write-back stage for the multicycle datapath. Selects one of `NUM_SRC` result sources (ALU out, MDR, HI, LO, PC, LT, shifter, immediate, extensions) with a `sel` code, captures the selected value with its destination register number into a small FIFO, and drains it toward the register bank with a valid/ready handshake. A combinational lookup port gives the newest buffered value for a register address, for forwarding while the write is still pending.

## Interface
- `WIDTH`, 32, data width of every source and of stored entries
- `NUM_SRC`, 8, number of selectable sources (2..16)
- `SEL_W`, 3, width of `sel`; must satisfy 2^SEL_W >= NUM_SRC
- `DEPTH`, 2, FIFO entries (1..8)
- `ADDR_W`, 5, register address width

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1 system clock, all state on rising edge
- `reset` in 1 synchronous, active-high
- `sel` in SEL_W source select, sampled on accepted push
- `src` in NUM_SRC*WIDTH flattened sources; source i at bits [i*WIDTH +: WIDTH]
- `dest` in ADDR_W destination register of the push
- `in_valid` in 1 push request
- `in_ready` out 1 buffer can accept
- `out_valid` out 1 head entry present
- `out_data` out WIDTH head data
- `out_dest` out ADDR_W head destination
- `out_ready` in 1 consumer (register bank) takes head
- `lookup_addr` in ADDR_W forwarding query address
- `lookup_hit` out 1 a buffered entry matches
- `lookup_data` out WIDTH newest matching data
- `sel_err` out 1 sticky: out-of-range select was pushed
- `count` out $clog2(DEPTH+1) occupied entries

## Operation
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- On push: entry = {`src[sel]`, `dest`} written at tail. If `sel >= NUM_SRC`: entry data = 0, dest still stored, `sel_err` set to 1 and held until reset.
- `in_ready = (count < DEPTH)`; no same-cycle pass-through when full (push blocked even if pop occurs).
- `out_valid = (count != 0)`; `out_data`/`out_dest` driven from head register; stable while `out_valid && !out_ready`.
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, head advances, tail advances.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Lookup (combinational): scan valid entries newest to oldest; first entry with `dest == lookup_addr` drives `lookup_data`, `lookup_hit = 1`. No match or `lookup_addr == 0`: `lookup_hit = 0`, `lookup_data = 0`. Entries with `dest == 0` still drain normally.
- Lookup reflects state before the current edge: an entry popped this cycle still hits this cycle; an entry pushed this cycle hits from the next cycle.
- `sel`, `src`, `dest` ignored when no push.

## Timing
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_dest`=0, `lookup_hit`=0, `lookup_data`=0, `sel_err`=0; pointers 0; entry storage cleared.
- Reset has priority over push/pop in the same cycle; entries in flight are discarded, no pop is signalled.
- Latency: push at edge k -> `out_valid`=1 after edge k (visible in cycle k+1). Minimum entry lifetime 1 cycle.
- Throughput: 1 push and 1 pop per cycle when not full.
- `in_ready`, `out_valid`, `count` are pure functions of registered state (no combinational path from `out_ready` or `in_valid`).
- `lookup_*` combinational from `lookup_addr` and registered state only.

## Test plan
- Reset then idle: `in_ready`=1, `out_valid`=0, `count`=0, `sel_err`=0; push sel=1 (src1=0x0000_ABCD), dest=8 -> next cycle `out_valid`=1, `out_data`=0x0000ABCD, `out_dest`=8.
- Fill with `out_ready`=0, DEPTH=2: push sel=0 (0x11) dest=3, sel=7 (0x77) dest=4 -> `count`=2, `in_ready`=0; third push ignored; raise `out_ready` -> pops 0x11/3 then 0x77/4 in order.
- Forwarding: buffer holds {0x5,dest=9} then {0x6,dest=9}; `lookup_addr`=9 -> hit=1, data=0x6; `lookup_addr`=0 with a dest-0 entry -> hit=0, data=0.
- Streaming: `in_valid`=`out_ready`=1 for 10 cycles, sel cycling 0..7 -> `count` stays 1, outputs match each push one cycle later, wrap-around exercised.
- Out-of-range: NUM_SRC=5, SEL_W=3, push sel=6 dest=2 -> entry data=0, `sel_err`=1 and stays 1 after drain until `reset`.
- Reset mid-operation: `count`=2, assert `reset` with simultaneous push and pop -> next cycle `count`=0, `out_valid`=0, `lookup_hit`=0, `sel_err`=0.

Source files
------------

// File: rtl/wb_select_buffer.sv
// Write-back source select feeding a small FIFO toward the register bank,
// with a combinational forwarding lookup over the pending entries.
module wb_select_buffer #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_SRC*WIDTH-1:0]     src,
  input  logic [ADDR_W-1:0]            dest,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [ADDR_W-1:0]            out_dest,
  input  logic                         out_ready,
  input  logic [ADDR_W-1:0]            lookup_addr,
  output logic                         lookup_hit,
  output logic [WIDTH-1:0]             lookup_data,
  output logic                         sel_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sel_err_q, sel_err_d;

  logic              sel_ok;
  logic [WIDTH-1:0]  push_data;
  logic              push, pop;
  logic [PTR_W-1:0]  lk_ptr;

  // Pointer wrap without modulo so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    sel_ok    = 1'b0;
    push_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == i) begin
        sel_ok    = 1'b1;
        push_data = src[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = data_q[head_q];
  assign out_dest  = dest_q[head_q];
  assign count     = count_q;
  assign sel_err   = sel_err_q;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    sel_err_d = sel_err_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
      if (!sel_ok) sel_err_d = 1'b1;
    end
    if (pop) head_d = ptr_inc(head_q);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      sel_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      sel_err_q <= sel_err_d;
      if (push) begin
        data_q[tail_q] <= push_data;
        dest_q[tail_q] <= dest;
      end
    end
  end

  // Walk oldest to newest; a later match overwrites, so the newest wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_ptr      = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < 32'(count_q) && lookup_addr != '0 && dest_q[lk_ptr] == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lk_ptr];
      end
      lk_ptr = ptr_inc(lk_ptr);
    end
  end

endmodule
